// File: rtl/pipe_pkg.sv
// Shared constants for the pipelined MIPS core.
// Holds the datapath and register-address widths, the ALU control width and
// the encodings of the EX operand-mux forwarding selects.
package pipe_pkg;

    localparam int DW  = 32;  // datapath width
    localparam int RW  = 5;   // register-address width
    localparam int ACW = 3;   // ALUControl width

    localparam logic [1:0] FWD_REG = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from WB result
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from MEM ALU result

endpackage

// File: rtl/fwd_unit.sv
// Operand-forwarding select generation for the EX operand muxes.
// Latency: purely combinational, zero cycles.
// Backpressure: none; selects follow the EX slot and the MEM/WB writers.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int RW = pipe_pkg::RW
) (
    input  logic          valid,
    input  logic [RW-1:0] rs,
    input  logic [RW-1:0] rt,
    input  logic          reg_write_mem,
    input  logic [RW-1:0] write_reg_mem,
    input  logic          reg_write_wb,
    input  logic [RW-1:0] write_reg_wb,
    output logic [1:0]    fa,
    output logic [1:0]    fb
);

    logic mem_live;
    logic wb_live;

    // A writer only forwards if it really writes and its target is not $0.
    assign mem_live = reg_write_mem & (write_reg_mem != '0);
    assign wb_live  = reg_write_wb  & (write_reg_wb  != '0);

    // A-side select: MEM result wins over WB; bubbles never forward.
    always_comb begin
        fa = FWD_REG;
        if (valid) begin
            if (mem_live && (write_reg_mem == rs)) begin
                fa = FWD_MEM;
            end else if (wb_live && (write_reg_wb == rs)) begin
                fa = FWD_WB;
            end
        end
    end

    // B-side select: same priority rule against the Rt field.
    always_comb begin
        fb = FWD_REG;
        if (valid) begin
            if (mem_live && (write_reg_mem == rt)) begin
                fb = FWD_MEM;
            end else if (wb_live && (write_reg_wb == rt)) begin
                fb = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and forwarding selects.
// Latency: one cycle ID->EX; a load-use hazard inserts exactly one bubble.
// Backpressure: Stall_Id holds PC and IF/ID while a bubble enters EX; Flush_Ex overrides.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DW = pipe_pkg::DW,
    parameter int RW = pipe_pkg::RW,
    parameter int CW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   DataOne_Id,
    input  logic [DW-1:0]   DataTwo_Id,
    input  logic [DW-1:0]   SignImm_Id,
    input  logic [RW-1:0]   Rs_Id,
    input  logic [RW-1:0]   Rt_Id,
    input  logic [RW-1:0]   Rd_Id,
    input  logic            RegWrite_Id,
    input  logic            MemtoReg_Id,
    input  logic            MemWrite_Id,
    input  logic            ALUSrc_Id,
    input  logic            RegDst_Id,
    input  logic [ACW-1:0]  ALUControl_Id,
    input  logic            Flush_Ex,
    input  logic            RegWrite_Mem,
    input  logic [RW-1:0]   WriteReg_Mem,
    input  logic            RegWrite_Wb,
    input  logic [RW-1:0]   WriteReg_Wb,
    output logic [DW-1:0]   DataOne_Ex,
    output logic [DW-1:0]   DataTwo_Ex,
    output logic [DW-1:0]   SignImm_Ex,
    output logic [RW-1:0]   Rs_Ex,
    output logic [RW-1:0]   Rt_Ex,
    output logic [RW-1:0]   Rd_Ex,
    output logic            RegWrite_Ex,
    output logic            MemtoReg_Ex,
    output logic            MemWrite_Ex,
    output logic            ALUSrc_Ex,
    output logic [ACW-1:0]  ALUControl_Ex,
    output logic [RW-1:0]   WriteReg_Ex,
    output logic            Valid_Ex,
    output logic [1:0]      FA,
    output logic [1:0]      FB,
    output logic            Stall_Id,
    output logic [CW-1:0]   StallCount
);

    logic            RegDst_Ex;
    logic            bubble;
    logic [CW-1:0]   count_one;

    assign count_one = {{(CW-1){1'b0}}, 1'b1};

    // A load in EX whose target feeds the instruction in ID cannot be forwarded in time.
    assign Stall_Id = Valid_Ex & MemtoReg_Ex & RegWrite_Ex & (Rt_Ex != '0)
                    & ((Rt_Ex == Rs_Id) | (Rt_Ex == Rt_Id));

    // A redirect squashes the slot regardless of the hold; both load an all-zero bubble.
    assign bubble = Stall_Id | Flush_Ex;

    assign WriteReg_Ex = RegDst_Ex ? Rd_Ex : Rt_Ex;

    // EX slot register: bubble clears everything, otherwise capture the ID bundle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DataOne_Ex    <= '0;
            DataTwo_Ex    <= '0;
            SignImm_Ex    <= '0;
            Rs_Ex         <= '0;
            Rt_Ex         <= '0;
            Rd_Ex         <= '0;
            RegWrite_Ex   <= 1'b0;
            MemtoReg_Ex   <= 1'b0;
            MemWrite_Ex   <= 1'b0;
            ALUSrc_Ex     <= 1'b0;
            RegDst_Ex     <= 1'b0;
            ALUControl_Ex <= '0;
            Valid_Ex      <= 1'b0;
        end else if (bubble) begin
            DataOne_Ex    <= '0;
            DataTwo_Ex    <= '0;
            SignImm_Ex    <= '0;
            Rs_Ex         <= '0;
            Rt_Ex         <= '0;
            Rd_Ex         <= '0;
            RegWrite_Ex   <= 1'b0;
            MemtoReg_Ex   <= 1'b0;
            MemWrite_Ex   <= 1'b0;
            ALUSrc_Ex     <= 1'b0;
            RegDst_Ex     <= 1'b0;
            ALUControl_Ex <= '0;
            Valid_Ex      <= 1'b0;
        end else begin
            DataOne_Ex    <= DataOne_Id;
            DataTwo_Ex    <= DataTwo_Id;
            SignImm_Ex    <= SignImm_Id;
            Rs_Ex         <= Rs_Id;
            Rt_Ex         <= Rt_Id;
            Rd_Ex         <= Rd_Id;
            RegWrite_Ex   <= RegWrite_Id;
            MemtoReg_Ex   <= MemtoReg_Id;
            MemWrite_Ex   <= MemWrite_Id;
            ALUSrc_Ex     <= ALUSrc_Id;
            RegDst_Ex     <= RegDst_Id;
            ALUControl_Ex <= ALUControl_Id;
            Valid_Ex      <= 1'b1;
        end
    end

    // Count only stalls that actually hold the front end; saturate rather than wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            StallCount <= '0;
        end else if (Stall_Id && !Flush_Ex && (StallCount != '1)) begin
            StallCount <= StallCount + count_one;
        end
    end

    fwd_unit #(
        .RW (RW)
    ) u_fwd (
        .valid         (Valid_Ex),
        .rs            (Rs_Ex),
        .rt            (Rt_Ex),
        .reg_write_mem (RegWrite_Mem),
        .write_reg_mem (WriteReg_Mem),
        .reg_write_wb  (RegWrite_Wb),
        .write_reg_wb  (WriteReg_Wb),
        .fa            (FA),
        .fb            (FB)
    );

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage built with a 4-bit stall counter.
// Table of directed vectors applied one per clock, then hand-written
// sequences for asynchronous reset, flush-during-stall and counter saturation.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [DW-1:0]   DataOne_Id = '0, DataTwo_Id = '0, SignImm_Id = '0;
    logic [RW-1:0]   Rs_Id = '0, Rt_Id = '0, Rd_Id = '0;
    logic            RegWrite_Id = 1'b0, MemtoReg_Id = 1'b0, MemWrite_Id = 1'b0;
    logic            ALUSrc_Id = 1'b0, RegDst_Id = 1'b0;
    logic [2:0]      ALUControl_Id = '0;
    logic            Flush_Ex = 1'b0;
    logic            RegWrite_Mem = 1'b0, RegWrite_Wb = 1'b0;
    logic [RW-1:0]   WriteReg_Mem = '0, WriteReg_Wb = '0;

    logic [DW-1:0]   DataOne_Ex, DataTwo_Ex, SignImm_Ex;
    logic [RW-1:0]   Rs_Ex, Rt_Ex, Rd_Ex, WriteReg_Ex;
    logic            RegWrite_Ex, MemtoReg_Ex, MemWrite_Ex, ALUSrc_Ex, Valid_Ex, Stall_Id;
    logic [2:0]      ALUControl_Ex;
    logic [1:0]      FA, FB;
    logic [CW-1:0]   StallCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .DataOne_Id(DataOne_Id), .DataTwo_Id(DataTwo_Id), .SignImm_Id(SignImm_Id),
        .Rs_Id(Rs_Id), .Rt_Id(Rt_Id), .Rd_Id(Rd_Id),
        .RegWrite_Id(RegWrite_Id), .MemtoReg_Id(MemtoReg_Id), .MemWrite_Id(MemWrite_Id),
        .ALUSrc_Id(ALUSrc_Id), .RegDst_Id(RegDst_Id), .ALUControl_Id(ALUControl_Id),
        .Flush_Ex(Flush_Ex),
        .RegWrite_Mem(RegWrite_Mem), .WriteReg_Mem(WriteReg_Mem),
        .RegWrite_Wb(RegWrite_Wb), .WriteReg_Wb(WriteReg_Wb),
        .DataOne_Ex(DataOne_Ex), .DataTwo_Ex(DataTwo_Ex), .SignImm_Ex(SignImm_Ex),
        .Rs_Ex(Rs_Ex), .Rt_Ex(Rt_Ex), .Rd_Ex(Rd_Ex),
        .RegWrite_Ex(RegWrite_Ex), .MemtoReg_Ex(MemtoReg_Ex), .MemWrite_Ex(MemWrite_Ex),
        .ALUSrc_Ex(ALUSrc_Ex), .ALUControl_Ex(ALUControl_Ex), .WriteReg_Ex(WriteReg_Ex),
        .Valid_Ex(Valid_Ex), .FA(FA), .FB(FB), .Stall_Id(Stall_Id), .StallCount(StallCount)
    );

    typedef struct {
        logic [31:0] d1;
        logic [4:0]  rs, rt, rd;
        logic        rw, m2r, regdst, flush, rwm;
        logic [4:0]  wrm;
        logic        rww;
        logic [4:0]  wrw;
        logic [31:0] e_d1;
        logic [4:0]  e_wr;
        logic        e_valid;
        logic [1:0]  e_fa, e_fb;
        logic        e_stall;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive the ID bundle; DataTwo and SignImm are derived from DataOne so they can be checked too.
    task automatic drive_id(input logic [31:0] d1, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic rw, input logic m2r, input logic regdst);
        DataOne_Id    = d1;
        DataTwo_Id    = d1 + 32'd1;
        SignImm_Id    = d1 + 32'd2;
        Rs_Id         = rs;
        Rt_Id         = rt;
        Rd_Id         = rd;
        RegWrite_Id   = rw;
        MemtoReg_Id   = m2r;
        MemWrite_Id   = 1'b0;
        ALUSrc_Id     = m2r;
        RegDst_Id     = regdst;
        ALUControl_Id = 3'd2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          d1   rs rt rd rw m2r rd fl rwm wrm rww wrw  e_d1 e_wr v  fa fb st cnt
        vecs[0] = '{5,   1, 2, 3, 1, 0,  1, 0, 0,  0,  0,  0,   5,   3,  1, 0, 0, 0, 0};
        vecs[1] = '{11,  4, 4, 9, 1, 0,  0, 0, 1,  4,  1,  4,   11,  4,  1, 2, 2, 0, 0};
        vecs[2] = '{12,  4, 4, 9, 1, 0,  0, 0, 0,  4,  1,  4,   12,  4,  1, 1, 1, 0, 0};
        vecs[3] = '{13,  0, 0, 0, 1, 0,  0, 0, 1,  0,  1,  0,   13,  0,  1, 0, 0, 0, 0};
        vecs[4] = '{20,  6, 7, 8, 1, 0,  1, 0, 1,  7,  1,  6,   20,  8,  1, 1, 2, 0, 0};
        vecs[5] = '{20,  6, 7, 8, 1, 0,  1, 1, 1,  7,  1,  6,   0,   0,  0, 0, 0, 0, 0};
        vecs[6] = '{100, 1, 4, 0, 1, 1,  0, 0, 0,  0,  0,  0,   100, 4,  1, 0, 0, 1, 0};
        vecs[7] = '{1,   4, 5, 6, 1, 0,  1, 0, 0,  0,  0,  0,   0,   0,  0, 0, 0, 0, 1};
        vecs[8] = '{1,   4, 5, 6, 1, 0,  1, 0, 0,  0,  1,  4,   1,   6,  1, 1, 0, 0, 1};

        // Reset held from time 0 with nonzero inputs present.
        drive_id(32'hdead_beef, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1);
        RegWrite_Mem = 1'b1; WriteReg_Mem = 5'd9;
        repeat (2) tick();
        check("reset Valid_Ex", 32'(Valid_Ex), 32'd0);
        check("reset DataOne_Ex", DataOne_Ex, 32'd0);
        check("reset StallCount", 32'(StallCount), 32'd0);
        check("reset FA", 32'(FA), 32'd0);
        rst = 1'b1;
        RegWrite_Mem = 1'b0; WriteReg_Mem = '0;

        for (int i = 0; i < 9; i++) begin
            drive_id(vecs[i].d1, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                     vecs[i].rw, vecs[i].m2r, vecs[i].regdst);
            Flush_Ex     = vecs[i].flush;
            RegWrite_Mem = vecs[i].rwm;
            WriteReg_Mem = vecs[i].wrm;
            RegWrite_Wb  = vecs[i].rww;
            WriteReg_Wb  = vecs[i].wrw;
            tick();
            check($sformatf("v%0d DataOne_Ex", i), DataOne_Ex, vecs[i].e_d1);
            check($sformatf("v%0d DataTwo_Ex", i), DataTwo_Ex,
                  vecs[i].e_valid ? vecs[i].e_d1 + 32'd1 : 32'd0);
            check($sformatf("v%0d SignImm_Ex", i), SignImm_Ex,
                  vecs[i].e_valid ? vecs[i].e_d1 + 32'd2 : 32'd0);
            check($sformatf("v%0d RegWrite_Ex", i), 32'(RegWrite_Ex), 32'(vecs[i].e_valid));
            check($sformatf("v%0d WriteReg_Ex", i), 32'(WriteReg_Ex), 32'(vecs[i].e_wr));
            check($sformatf("v%0d Valid_Ex", i), 32'(Valid_Ex), 32'(vecs[i].e_valid));
            check($sformatf("v%0d FA", i), 32'(FA), 32'(vecs[i].e_fa));
            check($sformatf("v%0d FB", i), 32'(FB), 32'(vecs[i].e_fb));
            check($sformatf("v%0d Stall_Id", i), 32'(Stall_Id), 32'(vecs[i].e_stall));
            check($sformatf("v%0d StallCount", i), 32'(StallCount), 32'(vecs[i].e_cnt));
        end

        // Asynchronous reset mid-cycle with a valid instruction in EX.
        #2;
        rst = 1'b0;
        #1;
        check("async rst Valid_Ex", 32'(Valid_Ex), 32'd0);
        check("async rst DataOne_Ex", DataOne_Ex, 32'd0);
        check("async rst WriteReg_Ex", 32'(WriteReg_Ex), 32'd0);
        check("async rst StallCount", 32'(StallCount), 32'd0);
        check("async rst FA", 32'(FA), 32'd0);
        tick();
        rst = 1'b1;
        RegWrite_Wb = 1'b0; WriteReg_Wb = '0;

        // Flush together with a load-use hazard: bubble, counter unchanged.
        drive_id(32'd50, 5'd1, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        check("lw in EX Valid_Ex", 32'(Valid_Ex), 32'd1);
        drive_id(32'd60, 5'd4, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1);
        Flush_Ex = 1'b1;
        #1;
        check("flush+stall Stall_Id", 32'(Stall_Id), 32'd1);
        tick();
        Flush_Ex = 1'b0;
        check("flush+stall Valid_Ex", 32'(Valid_Ex), 32'd0);
        check("flush+stall DataOne_Ex", DataOne_Ex, 32'd0);
        check("flush+stall StallCount", 32'(StallCount), 32'd0);

        // Saturation: a self-dependent load alternates capture and stall edges.
        drive_id(32'd70, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0);
        repeat (28) tick();
        check("sat count 14", 32'(StallCount), 32'd14);
        repeat (2) tick();
        check("sat count 15", 32'(StallCount), 32'd15);
        repeat (10) tick();
        check("sat hold 15", 32'(StallCount), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage pipelined MIPS core.
- Captures decoded operands, immediates and control from ID; presents them to EX.
- Generates the operand-forwarding selects FA/FB for the EX operand muxes (B-side mux: 00 register, 01 WB data, 10 MEM ALU result).
- Detects load-use hazards and inserts bubbles; counts stall cycles for performance monitoring.

Parameters:
- DW, 32, datapath width
- RW, 5, register-address width
- CW, 32, stall-counter width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- DataOne_Id  in  DW  register-file read port 1 (ID)
- DataTwo_Id  in  DW  register-file read port 2 (ID)
- SignImm_Id  in  DW  sign-extended immediate
- Rs_Id, Rt_Id, Rd_Id  in  RW each  source/destination fields
- RegWrite_Id, MemtoReg_Id, MemWrite_Id, ALUSrc_Id, RegDst_Id  in  1 each  control
- ALUControl_Id  in  3  ALU operation
- Flush_Ex  in  1  branch/jump redirect; next EX slot becomes a bubble
- RegWrite_Mem  in  1 / WriteReg_Mem  in  RW  MEM-stage writer
- RegWrite_Wb  in  1 / WriteReg_Wb  in  RW  WB-stage writer
- DataOne_Ex, DataTwo_Ex, SignImm_Ex  out  DW  registered operands
- Rs_Ex, Rt_Ex, Rd_Ex  out  RW  registered fields
- RegWrite_Ex, MemtoReg_Ex, MemWrite_Ex, ALUSrc_Ex  out  1  registered control
- ALUControl_Ex  out  3
- WriteReg_Ex  out  RW  RegDst_Ex ? Rd_Ex : Rt_Ex (combinational from registers)
- Valid_Ex  out  1  slot holds a real instruction
- FA, FB  out  2 each  forwarding selects
- Stall_Id  out  1  hold PC and IF/ID this cycle
- StallCount  out  CW  saturating load-use stall counter

Behaviour:
- Reset (rst=0, asynchronous): all registered outputs 0, Valid_Ex=0, StallCount=0. The bubble is all-zero, so RegWrite/MemWrite=0 and no architectural side effects occur. Reset asserted mid-operation discards the EX slot immediately.
- Load-use detect (combinational): Stall_Id = Valid_Ex & MemtoReg_Ex & RegWrite_Ex & (Rt_Ex != 0) & (Rt_Ex == Rs_Id | Rt_Ex == Rt_Id).
- Each rising edge, one of two cases applies:
  - Stall_Id | Flush_Ex: load a bubble (control 0, Valid_Ex=0, data/field registers 0).
  - Otherwise: capture all *_Id inputs, Valid_Ex=1.
- Latency: 1 cycle ID->EX. A load-use hazard costs exactly one bubble. The stalled instruction is captured on the following edge, when Stall_Id has deasserted because the load has moved to MEM.
- Simultaneous Flush_Ex and Stall_Id: bubble loads; Stall_Id is still driven as computed. The upstream redirect has priority over the hold.
- Forwarding (combinational from EX registers). FB:
  - 10 if RegWrite_Mem & WriteReg_Mem!=0 & WriteReg_Mem==Rt_Ex
  - else 01 if RegWrite_Wb & WriteReg_Wb!=0 & WriteReg_Wb==Rt_Ex
  - else 00
- FA uses the same rule with Rs_Ex. MEM has priority over WB.
- Register 0 is never forwarded. FA=FB=00 whenever Valid_Ex=0.
- StallCount increments by 1 on each edge where Stall_Id=1 and Flush_Ex=0. It saturates at all-ones; no wrap.
- No X propagation: every output has a defined value in every state.

Decomposition:
- Shared package pipe_pkg holds:
  - forwarding encodings FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - ALUControl width constant
  - widths DW/RW
- One sub-module, fwd_unit: purely combinational FA/FB generation, instantiated once. It is reusable by future EX/MEM forwarding work.
- The register bank and hazard logic stay in id_ex_stage.

Test Plan:
- Reset: drive inputs nonzero, pulse rst low mid-cycle -> all outputs 0 immediately, Valid_Ex=0, StallCount=0.
- Pass-through: add $3,$1,$2 with DataOne_Id=5, DataTwo_Id=7, RegDst=1 -> next cycle DataOne_Ex=5, DataTwo_Ex=7, WriteReg_Ex=3, Valid_Ex=1, FA=FB=00.
- Forwarding priority: Rt_Ex=4, RegWrite_Mem=1/WriteReg_Mem=4, RegWrite_Wb=1/WriteReg_Wb=4 -> FB=10; drop RegWrite_Mem -> FB=01; WriteReg=0 on both -> FB=00.
- Load-use: lw $4 in EX (MemtoReg_Ex=1, Rt_Ex=4), ID has Rs_Id=4 -> Stall_Id=1; next edge Valid_Ex=0, StallCount=1; following edge captures the held instruction.
- Flush with stall: Flush_Ex=1 and load-use together -> bubble loaded, StallCount unchanged.
- Saturation: preload StallCount to all-ones via forced stalls (CW=4 build) -> further stalls keep StallCount=15.
